// File: rtl/pq_pkg.sv
// Shared types and constants for the pq interface and its traffic generator.
package pq_pkg;

  localparam int unsigned KEY_WIDTH = 8;
  localparam int unsigned VAL_WIDTH = 8;

  // Queue item: ordering is on key only, value rides along.
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] value;
  } kv_t;

  typedef enum logic [1:0] {
    TG_IDLE,
    TG_FILL,
    TG_DRAIN,
    TG_DONE
  } tg_state_t;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11.
  localparam logic [15:0] TG_LFSR_TAPS = 16'hB400;

  // Error counters stick at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pq_if.sv
// Initiator/queue handshake bundle for a priority queue.
interface pq_if;
  import pq_pkg::*;

  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  modport master (output enq, deq, kvi, input kvo, full, empty, busy);
  modport slave  (input enq, deq, kvi, output kvo, full, empty, busy);

endinterface

// File: rtl/pq_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
module pq_lfsr16
  import pq_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_d;

  // Next value: load wins over advance; hold otherwise.
  always_comb begin
    q_d = q;
    if (load) begin
      q_d = seed;
    end else if (adv) begin
      q_d = q[0] ? ((q >> 1) ^ TG_LFSR_TAPS) : (q >> 1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/pq_traffic_gen.sv
// Priority-queue initiator: fills with LFSR keys, drains and checks min-first order.
module pq_traffic_gen
  import pq_pkg::*;
#(
  parameter int unsigned FILL_COUNT = 8,
  parameter int unsigned ROUNDS     = 4,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  pq_if.master        pq,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [7:0]  rounds_done
);

  localparam int unsigned CNT_W = $clog2(FILL_COUNT + 1) + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  tg_state_t            state_q, state_d;
  logic                 enq_q, enq_d;
  logic                 deq_q, deq_d;
  kv_t                  kvi_q, kvi_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic [CNT_W-1:0]     drain_q, drain_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [7:0]           err_d;
  logic [7:0]           rounds_d;
  logic [KEY_WIDTH-1:0] prev_q, prev_d;
  logic                 first_q, first_d;
  logic [VAL_WIDTH-1:0] seq_q, seq_d;
  logic                 done_d, pass_d;
  logic [15:0]          lfsr_q;
  logic                 unused_bits;

  assign pq.enq = enq_q;
  assign pq.deq = deq_q;
  assign pq.kvi = kvi_q;

  assign unused_bits = ^{lfsr_q[15:KEY_WIDTH], pq.kvo.value};

  // Key source; steps once per issued enqueue and is never reseeded between runs.
  pq_lfsr16 #(.RESET_VAL(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b0),
    .seed  (SEED),
    .adv   (enq_d),
    .q     (lfsr_q)
  );

  // Next-state, op issue and checking. An op is only issued when no op is in
  // flight, so full/empty always reflect every previously issued op.
  always_comb begin
    state_d  = state_q;
    enq_d    = 1'b0;
    deq_d    = 1'b0;
    kvi_d    = kvi_q;
    fill_d   = fill_q;
    drain_d  = drain_q;
    wd_d     = '0;
    err_d    = err_count;
    rounds_d = rounds_done;
    prev_d   = prev_q;
    first_d  = first_q;
    seq_d    = seq_q;

    // Head is valid during the dequeue cycle; check it against the previous key.
    if (state_q == TG_DRAIN && deq_q) begin
      if (!first_q && (pq.kvo.key < prev_q)) begin
        err_d = sat_inc8(err_d);
      end
      prev_d  = pq.kvo.key;
      first_d = 1'b0;
    end

    case (state_q)
      TG_IDLE, TG_DONE: begin
        if (start) begin
          state_d  = TG_FILL;
          fill_d   = '0;
          drain_d  = '0;
          err_d    = '0;
          rounds_d = '0;
          first_d  = 1'b1;
        end
      end
      TG_FILL, TG_DRAIN: begin
        if (pq.busy) begin
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            err_d   = sat_inc8(err_d);
            state_d = TG_DONE;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end else if (state_q == TG_FILL) begin
          if (fill_q == CNT_W'(FILL_COUNT)) begin
            state_d = TG_DRAIN;
          end else if (!enq_q) begin
            if (pq.full) begin
              // full together with empty is illegal; flag it and treat as full
              if (pq.empty) begin
                err_d = sat_inc8(err_d);
              end
              state_d = TG_DRAIN;
            end else begin
              enq_d       = 1'b1;
              kvi_d.key   = lfsr_q[KEY_WIDTH-1:0];
              kvi_d.value = seq_q;
              seq_d       = seq_q + VAL_WIDTH'(1);
              fill_d      = fill_q + CNT_W'(1);
            end
          end
        end else if (!deq_q) begin
          if (pq.full || !pq.empty) begin
            if (pq.full && pq.empty) begin
              err_d = sat_inc8(err_d);
            end
            deq_d   = 1'b1;
            drain_d = drain_q + CNT_W'(1);
          end else begin
            if (drain_q != fill_q) begin
              err_d = sat_inc8(err_d);
            end
            rounds_d = rounds_done + 8'd1;
            fill_d   = '0;
            drain_d  = '0;
            first_d  = 1'b1;
            state_d  = (rounds_d == 8'(ROUNDS)) ? TG_DONE : TG_FILL;
          end
        end
      end
      default: state_d = TG_IDLE;
    endcase

    done_d = (state_d == TG_DONE);
    pass_d = done_d && (err_d == 8'd0);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= TG_IDLE;
      enq_q       <= 1'b0;
      deq_q       <= 1'b0;
      kvi_q       <= '0;
      fill_q      <= '0;
      drain_q     <= '0;
      wd_q        <= '0;
      err_count   <= '0;
      rounds_done <= '0;
      prev_q      <= '0;
      first_q     <= 1'b1;
      seq_q       <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      state_q     <= state_d;
      enq_q       <= enq_d;
      deq_q       <= deq_d;
      kvi_q       <= kvi_d;
      fill_q      <= fill_d;
      drain_q     <= drain_d;
      wd_q        <= wd_d;
      err_count   <= err_d;
      rounds_done <= rounds_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      seq_q       <= seq_d;
      done        <= done_d;
      pass        <= pass_d;
    end
  end

endmodule

// File: tb/tb_pq_traffic_gen.sv
// Bench for pq_traffic_gen: behavioural priority/FIFO queue plus directed runs.
module tb_pq_traffic_gen;
  import pq_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          FILL = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done, pass;
  logic [7:0] err_count, rounds_done;

  pq_if pq();

  pq_traffic_gen #(
    .FILL_COUNT (FILL),
    .ROUNDS     (4),
    .SEED       (SEED),
    .TIMEOUT    (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pq          (pq),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .rounds_done (rounds_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Behavioural queue: min-key (stable) or FIFO head, runtime depth.
  kv_t  q[$];
  int   depth     = 16;
  bit   fifo_mode = 1'b0;
  bit   flush     = 1'b0;
  logic busy_r    = 1'b0;
  kv_t  kvo_r     = '0;
  logic full_r    = 1'b0;
  logic empty_r   = 1'b1;

  assign pq.kvo   = kvo_r;
  assign pq.full  = full_r;
  assign pq.empty = empty_r;
  assign pq.busy  = busy_r;

  function automatic int head_idx();
    int h = 0;
    if (!fifo_mode) begin
      for (int i = 1; i < q.size(); i++) begin
        if (q[i].key < q[h].key) h = i;
      end
    end
    return h;
  endfunction

  always @(posedge clk) begin
    if (flush || !rst_n) begin
      q.delete();
    end else begin
      if (pq.enq && q.size() < depth) q.push_back(pq.kvi);
      if (pq.deq && q.size() > 0) q.delete(head_idx());
    end
    full_r  <= (q.size() >= depth);
    empty_r <= (q.size() == 0);
    kvo_r   <= (q.size() == 0) ? kv_t'('0) : q[head_idx()];
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Protocol/data monitor, sampled just after each rising edge.
  logic [15:0]          m_lfsr = SEED;
  logic [7:0]           m_seq  = '0;
  logic [KEY_WIDTH-1:0] prev_key = '0;
  logic [KEY_WIDTH-1:0] first_keys [3];
  int n_since_rst  = 0;
  int run_enq      = 0;
  int run_deq      = 0;
  int exp_fifo_err = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      m_lfsr       = SEED;
      m_seq        = '0;
      n_since_rst  = 0;
      run_enq      = 0;
      run_deq      = 0;
      exp_fifo_err = 0;
    end else begin
      if (start) begin
        run_enq      = 0;
        run_deq      = 0;
        exp_fifo_err = 0;
      end
      if (pq.enq || pq.deq) chk("one_op", int'(pq.enq && pq.deq), 0);
      if (pq.enq) begin
        chk("enq_busy", int'(busy_r), 0);
        chk("enq_full", int'(q.size() >= depth), 0);
        chk("kvi_key", int'(pq.kvi.key), int'(m_lfsr[KEY_WIDTH-1:0]));
        chk("kvi_value", int'(pq.kvi.value), int'(m_seq));
        if ((run_enq % FILL) != 0 && m_lfsr[KEY_WIDTH-1:0] < prev_key) exp_fifo_err++;
        prev_key = m_lfsr[KEY_WIDTH-1:0];
        if (n_since_rst < 3) first_keys[n_since_rst] = pq.kvi.key;
        n_since_rst++;
        run_enq++;
        m_lfsr = lfsr_step(m_lfsr);
        m_seq  = m_seq + 8'd1;
      end
      if (pq.deq) begin
        chk("deq_busy", int'(busy_r), 0);
        chk("deq_empty", int'(q.size() == 0), 0);
        run_deq++;
      end
    end
  end

  typedef struct {
    string name;
    int    depth;
    int    fifo;
    int    busy_at;
    int    busy_len;
    int    exp_enq;
    int    exp_deq;
    int    exp_rounds;
    int    exp_err;   // -1: take the count from the FIFO descent model
  } vec_t;

  task automatic setup_queue(input int d, input int f);
    @(negedge clk);
    depth     = d;
    fifo_mode = (f != 0);
    flush     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s.done", name), int'(done), 1);
  endtask

  task automatic run_vec(input vec_t v);
    int e;
    setup_queue(v.depth, v.fifo);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.busy_len > 0) begin
      repeat (v.busy_at) @(negedge clk);
      busy_r = 1'b1;
      repeat (v.busy_len) @(negedge clk);
      busy_r = 1'b0;
    end
    wait_done(v.name);
    e = (v.exp_err < 0) ? exp_fifo_err : v.exp_err;
    if (v.exp_err < 0) chk($sformatf("%s.model_err_nonzero", v.name), int'(e > 0), 1);
    chk($sformatf("%s.err_count", v.name), int'(err_count), e);
    chk($sformatf("%s.pass", v.name), int'(pass), int'(e == 0));
    chk($sformatf("%s.rounds_done", v.name), int'(rounds_done), v.exp_rounds);
    chk($sformatf("%s.enq_count", v.name), run_enq, v.exp_enq);
    chk($sformatf("%s.deq_count", v.name), run_deq, v.exp_deq);
  endtask

  initial begin
    vec_t vt [7];
    int   n;
    vt[0] = '{"nominal",    16, 0, 0, 0,  32, 32, 4, 0};
    vt[1] = '{"depth8",      8, 0, 0, 0,  32, 32, 4, 0};
    vt[2] = '{"small_q",     4, 0, 0, 0,  16, 16, 4, 0};
    vt[3] = '{"depth1",      1, 0, 0, 0,   4,  4, 4, 0};
    vt[4] = '{"fifo_fault", 16, 1, 0, 0,  32, 32, 4, -1};
    vt[5] = '{"stall10",    16, 0, 4, 10, 32, 32, 4, 0};
    vt[6] = '{"watchdog",   16, 0, 4, 64,  2,  0, 0, 1};

    // Reset state, then idle without start.
    repeat (3) @(negedge clk);
    chk("rst_enq", int'(pq.enq), 0);
    chk("rst_deq", int'(pq.deq), 0);
    chk("rst_kvi", int'(pq.kvi), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_rounds", int'(rounds_done), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_done", int'(done), 0);
    chk("idle_enq", run_enq, 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vt[i]);
      if (i == 0) begin
        chk("first_key0", int'(first_keys[0]), 8'hE1);
        chk("first_key1", int'(first_keys[1]), 8'h70);
        chk("first_key2", int'(first_keys[2]), 8'h38);
      end
    end

    // Start pulses while busy running are ignored.
    setup_queue(16, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("restart_ignored");
    chk("restart_ignored.rounds", int'(rounds_done), 4);
    chk("restart_ignored.pass", int'(pass), 1);

    // Reset in the middle of a drain, then a clean rerun from the seed.
    setup_queue(16, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (run_deq < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("mid_drain_reached", int'(run_deq >= 2), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enq", int'(pq.enq), 0);
    chk("mid_rst_deq", int'(pq.deq), 0);
    chk("mid_rst_kvi", int'(pq.kvi), 0);
    chk("mid_rst_err", int'(err_count), 0);
    chk("mid_rst_rounds", int'(rounds_done), 0);
    chk("mid_rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0]);
    chk("rerun_first_key", int'(first_keys[0]), 8'hE1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
